// File: rtl/config_pkg.sv
// Shared configuration for the core: PC width, interrupt CSR bases and
// the CSR-op / PC-mux encodings used between the CSR unit and the PC path.
package config_pkg;

    parameter int unsigned IMemAddrWidth = 10;
    parameter logic [11:0] VecCsrBase    = 12'h7C0;
    parameter logic [11:0] EntryCsrBase  = 12'h7E0;

    // Bit 2 selects the immediate operand, bits [1:0] select RW/RS/RC.
    typedef enum logic [2:0] {
        CsrNop = 3'b000,
        CsrRw  = 3'b001,
        CsrRs  = 3'b010,
        CsrRc  = 3'b011,
        CsrRwi = 3'b101,
        CsrRsi = 3'b110,
        CsrRci = 3'b111
    } csr_op_t;

    typedef enum logic {
        PcSeq       = 1'b0,
        PcInterrupt = 1'b1
    } pc_interrupt_mux_t;

endpackage

// File: rtl/n_clic_stack_if.sv
// CSR access bus between the CSR unit (master) and the interrupt controller (slave).
interface n_clic_stack_if;

    logic                  csr_enable;
    logic [11:0]           csr_addr;
    logic [4:0]            rs1_zimm;
    logic [31:0]           rs1_data;
    config_pkg::csr_op_t   csr_op;
    logic [31:0]           csr_out;

    modport master (
        output csr_enable, csr_addr, rs1_zimm, rs1_data, csr_op,
        input  csr_out
    );

    modport slave (
        input  csr_enable, csr_addr, rs1_zimm, rs1_data, csr_op,
        output csr_out
    );

endinterface

// File: rtl/n_clic_stack.sv
// Nested interrupt controller with an explicit return stack, per-vector
// level/edge triggering and tail-chaining on interrupt return.
module n_clic_stack #(
    parameter int unsigned VecCount      = 8,
    parameter int unsigned PrioWidth     = 3,
    parameter int unsigned Depth         = 4,
    parameter int unsigned IMemAddrWidth = config_pkg::IMemAddrWidth,
    parameter logic [11:0] VecCsrBase    = config_pkg::VecCsrBase,
    parameter logic [11:0] EntryCsrBase  = config_pkg::EntryCsrBase
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    n_clic_stack_if.slave                     csr_bus,
    input  logic [VecCount-1:0]               irq_in_i,
    input  logic [IMemAddrWidth-1:0]          pc_in_i,
    output logic [IMemAddrWidth-1:0]          int_addr_o,
    output config_pkg::pc_interrupt_mux_t     pc_interrupt_sel_o,
    output logic [PrioWidth-1:0]              level_out_o,
    output logic                              interrupt_out_o,
    output logic [$clog2(Depth+1)-1:0]        depth_out_o
);

    localparam int unsigned DepthW = $clog2(Depth + 1);
    localparam int unsigned IdxW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned VecW   = $clog2(VecCount);
    localparam logic [11:0] MstatusAddr = 12'h300;
    localparam logic [11:0] ThreshAddr  = 12'h347;

    logic                     mie_q, mie_d;
    logic [PrioWidth-1:0]     thresh_q, thresh_d;
    logic [VecCount-1:0]      pend_q, pend_d, en_q, en_d, edge_q, edge_d, irq_q;
    logic [PrioWidth-1:0]     prio_q [VecCount];
    logic [PrioWidth-1:0]     prio_d [VecCount];
    logic [IMemAddrWidth-1:0] vec_q [VecCount];
    logic [IMemAddrWidth-1:0] vec_d [VecCount];
    logic [IMemAddrWidth-1:0] stk_pc_q [Depth];
    logic [IMemAddrWidth-1:0] stk_pc_d [Depth];
    logic [PrioWidth-1:0]     stk_prio_q [Depth];
    logic [PrioWidth-1:0]     stk_prio_d [Depth];
    logic [DepthW-1:0]        depth_q, depth_d;

    logic                 any_req;
    logic [PrioWidth-1:0] max_prio;
    logic [VecW-1:0]      max_vec;
    logic [IdxW-1:0]      top_idx, below_idx, push_idx;
    logic                 stack_empty, stack_full;
    logic [PrioWidth-1:0] top_prio, below_prio, run_thresh, ret_thresh;
    logic                 ret_req, do_ret, take, tail;

    logic        hit_mstatus, hit_thresh, csr_hit, csr_wr;
    logic [31:0] csr_old, csr_new, operand;
    logic        unused_csr_bits;

    assign unused_csr_bits = ^csr_new;

    // Arbitration: highest priority among enabled pending vectors, lowest index on ties.
    always_comb begin
        any_req  = 1'b0;
        max_prio = '0;
        max_vec  = '0;
        for (int unsigned i = 0; i < VecCount; i++) begin
            if (en_q[i] && pend_q[i] && (!any_req || prio_q[i] > max_prio)) begin
                any_req  = 1'b1;
                max_prio = prio_q[i];
                max_vec  = VecW'(i);
            end
        end
    end

    // Stack view, running/restored thresholds and the take/return decision.
    always_comb begin
        top_idx     = IdxW'(depth_q - DepthW'(1));
        below_idx   = IdxW'(depth_q - DepthW'(2));
        push_idx    = IdxW'(depth_q);
        stack_empty = (depth_q == '0);
        stack_full  = (depth_q == DepthW'(Depth));
        top_prio    = stack_empty ? '0 : stk_prio_q[top_idx];
        below_prio  = (depth_q > DepthW'(1)) ? stk_prio_q[below_idx] : '0;
        run_thresh  = (top_prio > thresh_q) ? top_prio : thresh_q;
        ret_thresh  = (below_prio > thresh_q) ? below_prio : thresh_q;
        ret_req     = (pc_in_i == '1);
        take        = !ret_req && mie_q && any_req && (max_prio > run_thresh) && !stack_full;
        // A return marker with nothing on the stack falls through as a plain sequential step.
        do_ret      = ret_req && !stack_empty;
        tail        = do_ret && mie_q && any_req && (max_prio > ret_thresh);
    end

    // PC mux drive and status outputs.
    always_comb begin
        int_addr_o         = pc_in_i + IMemAddrWidth'(1);
        pc_interrupt_sel_o = config_pkg::PcSeq;
        if (take || tail) begin
            int_addr_o         = vec_q[max_vec];
            pc_interrupt_sel_o = config_pkg::PcInterrupt;
        end else if (do_ret) begin
            int_addr_o         = stk_pc_q[top_idx];
            pc_interrupt_sel_o = config_pkg::PcInterrupt;
        end
        interrupt_out_o = take || tail;
        level_out_o     = top_prio;
        depth_out_o     = depth_q;
    end

    // CSR read mux and read-modify-write value.
    always_comb begin
        hit_mstatus = (csr_bus.csr_addr == MstatusAddr);
        hit_thresh  = (csr_bus.csr_addr == ThreshAddr);
        csr_hit     = hit_mstatus || hit_thresh;
        csr_old     = '0;
        if (hit_mstatus) csr_old = {28'b0, mie_q, 3'b0};
        if (hit_thresh)  csr_old = 32'(thresh_q);
        for (int unsigned i = 0; i < VecCount; i++) begin
            if (csr_bus.csr_addr == EntryCsrBase + 12'(i)) begin
                csr_hit = 1'b1;
                csr_old = 32'({prio_q[i], edge_q[i], en_q[i], pend_q[i]});
            end
            if (csr_bus.csr_addr == VecCsrBase + 12'(i)) begin
                csr_hit = 1'b1;
                csr_old = 32'(vec_q[i]);
            end
        end

        operand = csr_bus.csr_op[2] ? 32'(csr_bus.rs1_zimm) : csr_bus.rs1_data;
        csr_new = csr_old;
        csr_wr  = 1'b0;
        case (csr_bus.csr_op)
            config_pkg::CsrRw, config_pkg::CsrRwi: begin
                csr_new = operand;
                csr_wr  = 1'b1;
            end
            config_pkg::CsrRs, config_pkg::CsrRsi: begin
                csr_new = csr_old | operand;
                csr_wr  = (operand != '0);
            end
            config_pkg::CsrRc, config_pkg::CsrRci: begin
                csr_new = csr_old & ~operand;
                csr_wr  = (operand != '0);
            end
            default: ;
        endcase
        csr_wr          = csr_wr && csr_bus.csr_enable && csr_hit;
        csr_bus.csr_out = csr_bus.csr_enable ? csr_old : '0;
    end

    // Next state: hardware pend set, then software write, then stack action.
    always_comb begin
        mie_d      = mie_q;
        thresh_d   = thresh_q;
        pend_d     = pend_q;
        en_d       = en_q;
        edge_d     = edge_q;
        prio_d     = prio_q;
        vec_d      = vec_q;
        stk_pc_d   = stk_pc_q;
        stk_prio_d = stk_prio_q;
        depth_d    = depth_q;

        for (int unsigned i = 0; i < VecCount; i++) begin
            if (edge_q[i] ? (irq_in_i[i] && !irq_q[i]) : irq_in_i[i]) pend_d[i] = 1'b1;
        end

        if (csr_wr) begin
            if (hit_mstatus) mie_d = csr_new[3];
            if (hit_thresh)  thresh_d = csr_new[PrioWidth-1:0];
            for (int unsigned i = 0; i < VecCount; i++) begin
                if (csr_bus.csr_addr == EntryCsrBase + 12'(i)) begin
                    pend_d[i] = csr_new[0];
                    en_d[i]   = csr_new[1];
                    edge_d[i] = csr_new[2];
                    prio_d[i] = csr_new[3 +: PrioWidth];
                end
                if (csr_bus.csr_addr == VecCsrBase + 12'(i)) begin
                    vec_d[i] = csr_new[IMemAddrWidth-1:0];
                end
            end
        end

        // The serviced vector's pend clear overrides a same-cycle software set.
        if (take) begin
            stk_pc_d[push_idx]   = pc_in_i;
            stk_prio_d[push_idx] = max_prio;
            depth_d              = depth_q + DepthW'(1);
            pend_d[max_vec]      = 1'b0;
        end else if (tail) begin
            // Tail-chain keeps the original return PC, only the running priority changes.
            stk_prio_d[top_idx] = max_prio;
            pend_d[max_vec]     = 1'b0;
        end else if (do_ret) begin
            depth_d = depth_q - DepthW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mie_q    <= 1'b0;
            thresh_q <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            edge_q   <= '0;
            irq_q    <= '0;
            depth_q  <= '0;
            for (int unsigned i = 0; i < VecCount; i++) begin
                prio_q[i] <= '0;
                vec_q[i]  <= '0;
            end
            for (int unsigned i = 0; i < Depth; i++) begin
                stk_pc_q[i]   <= '0;
                stk_prio_q[i] <= '0;
            end
        end else begin
            mie_q      <= mie_d;
            thresh_q   <= thresh_d;
            pend_q     <= pend_d;
            en_q       <= en_d;
            edge_q     <= edge_d;
            irq_q      <= irq_in_i;
            depth_q    <= depth_d;
            prio_q     <= prio_d;
            vec_q      <= vec_d;
            stk_pc_q   <= stk_pc_d;
            stk_prio_q <= stk_prio_d;
        end
    end

endmodule

// File: doc/n_clic_stack.md
# n_clic_stack

Parametrised successor to the nested interrupt controller. It supports a configurable vector count, priority width and nesting depth, and per-vector level/edge trigger mode fed from hardware sources. It holds an explicit return stack with tail-chaining on interrupt return. It sits beside the PC register: it drives the interrupt target address into the PC branch mux and services the interrupt CSRs through the CSR unit.

## Interface
- VecCount, 8, number of interrupt vectors (2..32).
- PrioWidth, 3, priority bits per vector; threshold/level width.
- Depth, 4, return-stack entries (max nesting).
- IMemAddrWidth, config_pkg value, word-address width of PC/vector registers.
- VecCsrBase / EntryCsrBase, config_pkg values, CSR address of vector 0 target / entry.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- csr_enable  in  1  CSR access strobe this cycle
- csr_addr  in  12  CSR address
- rs1_zimm  in  5  immediate operand for CSRR*I
- rs1_data  in  32  register operand
- csr_op  in  csr_op_t  CSRRW/RS/RC and immediate forms
- irq_in  in  VecCount  hardware interrupt sources
- pc_in  in  IMemAddrWidth  current PC register value
- csr_out  out  32  old CSR value (zero-extended), 0 when not addressed
- int_addr  out  IMemAddrWidth  next PC (pc_in+1, vector target, or return PC)
- pc_interrupt_sel  out  pc_interrupt_mux_t  selects int_addr vs sequential PC
- level_out  out  PrioWidth  current running priority
- interrupt_out  out  1  interrupt take or tail-chain this cycle
- depth_out  out  $clog2(Depth+1)  current stack occupancy

## Operation
- Entry CSR per vector i: bit0 pend, bit1 enable, bit2 edge-mode, bits[3+PrioWidth-1:3] prio; others read 0. Vector CSR i: IMemAddrWidth-bit word target; upper bits ignored on write.
- mstatus (0x300): only bit3 MIE is stored. mintthresh (0x347): PrioWidth bits.
- CSR writes: RW replaces, RS ORs, RC clears; the immediate forms use rs1_zimm. RS/RC with operand 0 do not write. csr_out returns the pre-write value.
- Pending sources: level mode sets pend each cycle irq_in[i]=1. Edge mode sets pend on a 0->1 transition of a registered copy of irq_in. A software write to pend takes priority over hardware set in the same cycle.
- Arbitration is combinational over enabled&pended vectors: max prio wins; on a tie, the lowest index wins. Result: max_prio, max_vec.
- Effective threshold = max(mintthresh, prio on top of stack); with an empty stack it is mintthresh.
- Take when MIE && max_prio > threshold && depth < Depth and no return is in progress.
  - The following edge pushes {return PC = pc_in, prio}, clears the winner's pend and sets level_out = prio.
  - Same cycle: int_addr = vec[max_vec], pc_interrupt_sel = interrupt, interrupt_out = 1.
- Return: pc_in == all-ones (return marker).
  - If a pending vector has prio > the restored threshold (the entry below the top, or mintthresh), tail-chain: replace the top entry's prio, keep its return PC, set int_addr = that vector's target, interrupt_out = 1.
  - Otherwise pop and set int_addr = saved return PC.
- Stack full: takes are suppressed and pend is retained. A return with an empty stack is ignored: int_addr = pc_in + 1, wrapping.
- Higher-priority preemption nests up to Depth; equal priority never preempts.

## Timing
- Reset: all CSRs 0, stack empty, depth_out 0, level_out 0, interrupt_out 0, csr_out 0, int_addr = pc_in + 1, irq registers 0.
- Take/return decisions are combinational from registered state; state updates on the next rising clk.
- Pend set by CSR or irq_in in cycle N: int_addr shows the vector in cycle N+1; the push happens at the end of N+1.
- CSR read latency is 0 (combinational csr_out); the write commits at the clock edge.
- Software write of the same vector's pend in the take cycle: the take clear wins.
- Reset mid-nesting discards the stack immediately at the edge.

## Test plan
- Vectors 0,2,4,7 at prio 1,2,1,7, targets 2,4,8,14, MIE=1; pend 4 -> int_addr=8, level_out=1, depth_out=1.
- Then pend 0 (prio 1) -> no take. Pend 2 -> int_addr=4, depth 2. Pend 7 -> int_addr=14, depth 3.
- Depth=3, at full, pend another prio-7 vector -> no take, pend held. Return marker -> pop to level 2, int_addr = saved PC.
- Tail-chain: inside vec 2 with vec 4 pending, return -> int_addr=8 directly, depth unchanged, level_out=1.
- Edge mode on vec 3: hold irq_in[3] high 5 cycles -> exactly one pend. Level mode -> pend re-asserts after clear.
- CSR: CSRRSI 0 on VecCsrBase -> csr_out=2, no write. CSRRW 'hfffffff on VecCsrBase+2 -> csr_out=4, then readback 'h3ff for width 10.
